// File: rtl/transistor_switch_scheduler.sv
// Round-robin time-slot scheduler: grants one transistor channel at a time for a
// programmed ON time, then holds all drives low for a programmable dead-time.
module transistor_switch_scheduler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    localparam int ID_W = $clog2(N_CH)
) (
    input  logic             clk_2sec,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_CH-1:0]  req,
    input  logic [CNT_W-1:0] on_ticks,
    input  logic [CNT_W-1:0] gap_ticks,
    output logic [N_CH-1:0]  drive,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  done_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_nextPtr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [N_CH-1:0]  w_nextDrive;
    logic [ID_W-1:0]  w_nextGrantId;
    logic             w_nextDone;
    logic [ID_W-1:0]  w_nextDoneId;

    logic             w_found;
    logic [ID_W-1:0]  w_gnt;
    logic [ID_W-1:0]  w_gntPlus1;
    logic [CNT_W-1:0] w_onLoad;

    function automatic logic [ID_W-1:0] wrapIdx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) s = s - N_CH;
        return ID_W'(s);
    endfunction

    // First requesting channel at or after the pointer, wrapping at N_CH.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_found && req[wrapIdx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_gnt   = wrapIdx(r_ptr, k);
            end
        end
    end

    assign w_gntPlus1 = (w_gnt == ID_W'(N_CH - 1)) ? '0 : w_gnt + ID_W'(1);
    assign w_onLoad   = (on_ticks == '0) ? '0 : on_ticks - CNT_W'(1);
    assign busy       = (r_state != ST_IDLE);

    always_comb begin
        w_nextState   = r_state;
        w_nextPtr     = r_ptr;
        w_nextCnt     = r_cnt;
        w_nextDrive   = drive;
        w_nextGrantId = grant_id;
        w_nextDone    = 1'b0;
        w_nextDoneId  = done_id;
        case (r_state)
            ST_IDLE: begin
                w_nextDrive = '0;
                if (enable && w_found) begin
                    w_nextDrive   = N_CH'(1) << w_gnt;
                    w_nextGrantId = w_gnt;
                    w_nextCnt     = w_onLoad;
                    w_nextPtr     = w_gntPlus1;
                    w_nextState   = ST_ON;
                end
            end
            ST_ON: begin
                // Losing enable aborts silently; the pointer already moved past this channel.
                if (!enable) begin
                    w_nextDrive = '0;
                    w_nextCnt   = '0;
                    w_nextState = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end else begin
                    w_nextDrive  = '0;
                    w_nextDone   = 1'b1;
                    w_nextDoneId = grant_id;
                    if (gap_ticks == '0) begin
                        w_nextCnt   = '0;
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextCnt   = gap_ticks - CNT_W'(1);
                        w_nextState = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                w_nextDrive = '0;
                if (!enable || r_cnt == '0) begin
                    w_nextCnt   = '0;
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_nextDrive = '0;
                w_nextCnt   = '0;
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2sec) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            drive    <= '0;
            grant_id <= '0;
            done     <= 1'b0;
            done_id  <= '0;
        end else begin
            r_state  <= w_nextState;
            r_ptr    <= w_nextPtr;
            r_cnt    <= w_nextCnt;
            drive    <= w_nextDrive;
            grant_id <= w_nextGrantId;
            done     <= w_nextDone;
            done_id  <= w_nextDoneId;
        end
    end

endmodule

// File: tb/tb_transistor_switch_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a slot-level behavioural model.
module tb_transistor_switch_scheduler;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int ID_W  = $clog2(N_CH);

    logic             clk_2sec = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [N_CH-1:0]  req;
    logic [CNT_W-1:0] on_ticks;
    logic [CNT_W-1:0] gap_ticks;
    logic [N_CH-1:0]  drive;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             done;
    logic [ID_W-1:0]  done_id;

    int checks = 0;
    int errors = 0;

    // Model: whether a channel is driven, how many ON ticks remain (including the
    // current one), how many dead ticks remain before arbitration resumes.
    bit modelValid = 1'b0;
    bit mActive;
    int mOnLeft;
    int mGapLeft;
    int mPtr;
    int mId;
    bit mDone;
    int mDoneId;

    transistor_switch_scheduler #(
        .N_CH (N_CH),
        .CNT_W(CNT_W)
    ) dut (
        .clk_2sec (clk_2sec),
        .rst_n    (rst_n),
        .enable   (enable),
        .req      (req),
        .on_ticks (on_ticks),
        .gap_ticks(gap_ticks),
        .drive    (drive),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id)
    );

    always #5 clk_2sec = ~clk_2sec;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelStep();
        int g;
        mDone = 1'b0;
        if (!rst_n) begin
            mActive    = 1'b0;
            mOnLeft    = 0;
            mGapLeft   = 0;
            mPtr       = 0;
            mId        = 0;
            mDoneId    = 0;
            modelValid = 1'b1;
        end else if (mActive) begin
            if (!enable) begin
                mActive = 1'b0;
            end else if (mOnLeft > 1) begin
                mOnLeft--;
            end else begin
                mActive  = 1'b0;
                mDone    = 1'b1;
                mDoneId  = mId;
                mGapLeft = int'(gap_ticks);
            end
        end else if (mGapLeft > 0) begin
            if (!enable) mGapLeft = 0;
            else mGapLeft--;
        end else if (enable && req != '0) begin
            g = -1;
            for (int k = 0; k < N_CH; k++) begin
                if (g < 0 && req[(mPtr + k) % N_CH]) g = (mPtr + k) % N_CH;
            end
            mActive = 1'b1;
            mId     = g;
            mOnLeft = (on_ticks == '0) ? 1 : int'(on_ticks);
            mPtr    = (g + 1) % N_CH;
        end
    endtask

    initial forever begin
        @(posedge clk_2sec);
        modelStep();
    end

    // Outputs are compared mid-cycle, away from the active edge.
    initial forever begin
        logic [N_CH-1:0] expDrive;
        @(negedge clk_2sec);
        if (modelValid) begin
            expDrive = mActive ? (N_CH'(1) << mId) : '0;
            checkOutput("model drive", 32'(drive), 32'(expDrive));
            checkOutput("model grant_id", 32'(grant_id), 32'(mId));
            checkOutput("model busy", 32'(busy), 32'(mActive || mGapLeft > 0));
            checkOutput("model done", 32'(done), 32'(mDone));
            if (mDone) checkOutput("model done_id", 32'(done_id), 32'(mDoneId));
            checkOutput("drive onehot", 32'($countones(drive) <= 1), 32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_2sec);
    endtask

    task automatic applyStimulus(input logic en, input logic [N_CH-1:0] r,
                                 input logic [CNT_W-1:0] onT, input logic [CNT_W-1:0] gapT);
        enable    = en;
        req       = r;
        on_ticks  = onT;
        gap_ticks = gapT;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        tick(2);
        checkOutput("reset drive", 32'(drive), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);

        // Single request: 3-tick ON, 2-tick gap, then re-grant.
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'b0100, 8'd3, 8'd2);
        tick(1);
        checkOutput("single first drive", 32'(drive), 32'h4);
        checkOutput("single busy", 32'(busy), 32'd1);
        tick(2);
        checkOutput("single third drive", 32'(drive), 32'h4);
        tick(1);
        checkOutput("single fall drive", 32'(drive), 32'd0);
        checkOutput("single done", 32'(done), 32'd1);
        checkOutput("single done_id", 32'(done_id), 32'd2);
        tick(1);
        checkOutput("single gap busy", 32'(busy), 32'd1);
        checkOutput("single done pulse", 32'(done), 32'd0);
        tick(1);
        checkOutput("single idle busy", 32'(busy), 32'd0);
        tick(1);
        checkOutput("single regrant", 32'(drive), 32'h4);

        rst_n = 1'b0;
        tick(1);
        checkOutput("reset mid-ON drive", 32'(drive), 32'd0);
        checkOutput("reset mid-ON busy", 32'(busy), 32'd0);

        // Round-robin with all channels requesting.
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'b1111, 8'd1, 8'd0);
        tick(1);
        checkOutput("rr grant0", 32'(drive), 32'h1);
        tick(1);
        checkOutput("rr idle", 32'(drive), 32'd0);
        tick(1);
        checkOutput("rr grant1", 32'(drive), 32'h2);
        tick(2);
        checkOutput("rr grant2", 32'(drive), 32'h4);
        tick(2);
        checkOutput("rr grant3", 32'(drive), 32'h8);
        tick(2);
        checkOutput("rr grant0 again", 32'(drive), 32'h1);

        // Wrap and skip.
        req = 4'b1000;
        tick(2);
        checkOutput("skip to 3", 32'(drive), 32'h8);
        req = 4'b0010;
        tick(2);
        checkOutput("wrap drive", 32'(drive), 32'h2);
        checkOutput("wrap grant_id", 32'(grant_id), 32'd1);

        // Zero programming: one tick on, one tick off.
        applyStimulus(1'b1, 4'b0001, 8'd0, 8'd0);
        tick(2);
        checkOutput("zero on", 32'(drive), 32'h1);
        tick(1);
        checkOutput("zero off", 32'(drive), 32'd0);
        checkOutput("zero done", 32'(done), 32'd1);
        checkOutput("zero done_id", 32'(done_id), 32'd0);
        tick(1);
        checkOutput("zero on again", 32'(drive), 32'h1);
        tick(1);
        checkOutput("zero done again", 32'(done), 32'd1);

        // Abort on the second tick of a 5-tick slot for channel 1.
        applyStimulus(1'b1, 4'b0010, 8'd5, 8'd0);
        tick(1);
        checkOutput("abort slot start", 32'(drive), 32'h2);
        tick(1);
        enable = 1'b0;
        tick(1);
        checkOutput("abort drive", 32'(drive), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort no done", 32'(done), 32'd0);
        applyStimulus(1'b1, 4'b1111, 8'd5, 8'd0);
        tick(1);
        checkOutput("abort next grant", 32'(drive), 32'h4);
        checkOutput("abort next grant_id", 32'(grant_id), 32'd2);

        // Reset during the dead-time.
        applyStimulus(1'b1, 4'b1111, 8'd1, 8'd3);
        tick(5);
        checkOutput("gap entry done", 32'(done), 32'd1);
        checkOutput("gap entry busy", 32'(busy), 32'd1);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        checkOutput("reset mid-GAP busy", 32'(busy), 32'd0);
        checkOutput("reset mid-GAP drive", 32'(drive), 32'd0);
        rst_n = 1'b1;
        tick(1);
        checkOutput("post-reset grant", 32'(drive), 32'h1);
        checkOutput("post-reset grant_id", 32'(grant_id), 32'd0);

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (enable) begin
                if ($urandom_range(0, 39) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) req = N_CH'($urandom);
            on_ticks  = ($urandom_range(0, 199) == 0) ? 8'hFF : CNT_W'($urandom_range(0, 6));
            gap_ticks = ($urandom_range(0, 199) == 0) ? 8'hFF : CNT_W'($urandom_range(0, 4));
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
